// File: rtl/fb_vga_reader.sv
// 640x480@60 VGA scan-out from a half-resolution RGB444 frame buffer, 2x upscaled.
// Counter state reaches the VGA pins three clocks later; frame_end is not delayed.
module fb_vga_reader #(
  parameter int c_img_cols    = 320,
  parameter int c_img_rows    = 240,
  parameter int c_nb_img_pxls = 17,
  parameter int c_nb_buf      = 12,
  parameter int c_h_visible   = 640,
  parameter int c_h_front     = 16,
  parameter int c_h_sync      = 96,
  parameter int c_h_back      = 48,
  parameter int c_v_visible   = 480,
  parameter int c_v_front     = 10,
  parameter int c_v_sync      = 2,
  parameter int c_v_back      = 33
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic [c_nb_img_pxls-1:0] addrb,
  input  logic [c_nb_buf-1:0]      doutb,
  output logic                     vga_hsync,
  output logic                     vga_vsync,
  output logic [3:0]               vga_red,
  output logic [3:0]               vga_green,
  output logic [3:0]               vga_blue,
  output logic                     frame_end
);

  localparam int c_h_total = c_h_visible + c_h_front + c_h_sync + c_h_back;
  localparam int c_v_total = c_v_visible + c_v_front + c_v_sync + c_v_back;
  localparam int c_nb_h    = $clog2(c_h_total);
  localparam int c_nb_v    = $clog2(c_v_total);

  localparam logic [c_nb_h-1:0] c_h_last       = c_nb_h'(c_h_total - 1);
  localparam logic [c_nb_h-1:0] c_h_vis        = c_nb_h'(c_h_visible);
  localparam logic [c_nb_h-1:0] c_h_vis_last   = c_nb_h'(c_h_visible - 1);
  localparam logic [c_nb_h-1:0] c_h_sync_first = c_nb_h'(c_h_visible + c_h_front);
  localparam logic [c_nb_h-1:0] c_h_sync_last  = c_nb_h'(c_h_visible + c_h_front + c_h_sync - 1);

  localparam logic [c_nb_v-1:0] c_v_last       = c_nb_v'(c_v_total - 1);
  localparam logic [c_nb_v-1:0] c_v_vis        = c_nb_v'(c_v_visible);
  localparam logic [c_nb_v-1:0] c_v_vis_last   = c_nb_v'(c_v_visible - 1);
  localparam logic [c_nb_v-1:0] c_v_sync_first = c_nb_v'(c_v_visible + c_v_front);
  localparam logic [c_nb_v-1:0] c_v_sync_last  = c_nb_v'(c_v_visible + c_v_front + c_v_sync - 1);

  localparam logic [c_nb_img_pxls-1:0] c_row_step = c_nb_img_pxls'(c_img_cols);

  logic [c_nb_h-1:0]        h;
  logic [c_nb_v-1:0]        v;
  logic [c_nb_img_pxls-1:0] row_base;
  logic                     visible;
  logic                     hsync_raw;
  logic                     vsync_raw;
  logic                     h_wrap;
  logic [1:0]               vis_pipe;
  logic [1:0]               hsync_pipe;
  logic [1:0]               vsync_pipe;

  assign h_wrap    = (h == c_h_last);
  assign visible   = (h < c_h_vis) && (v < c_v_vis);
  assign hsync_raw = !((h >= c_h_sync_first) && (h <= c_h_sync_last));
  assign vsync_raw = !((v >= c_v_sync_first) && (v <= c_v_sync_last));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h <= '0;
      v <= '0;
    end else if (h_wrap) begin
      h <= '0;
      if (v == c_v_last) v <= '0;
      else               v <= v + 1'b1;
    end else begin
      h <= h + 1'b1;
    end
  end

  // Each stored row is shown on two lines, so the base advances after odd lines only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_base <= '0;
    end else if (h_wrap) begin
      if (v == c_v_last)                  row_base <= '0;
      else if (v[0] && (v < c_v_vis_last)) row_base <= row_base + c_row_step;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addrb      <= '0;
      vis_pipe   <= '0;
      hsync_pipe <= 2'b11;
      vsync_pipe <= 2'b11;
      frame_end  <= 1'b0;
    end else begin
      if (visible) addrb <= row_base + c_nb_img_pxls'(h[c_nb_h-1:1]);
      vis_pipe   <= {vis_pipe[0], visible};
      hsync_pipe <= {hsync_pipe[0], hsync_raw};
      vsync_pipe <= {vsync_pipe[0], vsync_raw};
      frame_end  <= (h == c_h_vis_last) && (v == c_v_vis_last);
    end
  end

  // Third stage: doutb now belongs to the pixel whose flags sit at the end of the pipes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vga_hsync <= 1'b1;
      vga_vsync <= 1'b1;
      vga_red   <= '0;
      vga_green <= '0;
      vga_blue  <= '0;
    end else begin
      vga_hsync <= hsync_pipe[1];
      vga_vsync <= vsync_pipe[1];
      if (vis_pipe[1]) begin
        vga_red   <= doutb[11:8];
        vga_green <= doutb[7:4];
        vga_blue  <= doutb[3:0];
      end else begin
        vga_red   <= '0;
        vga_green <= '0;
        vga_blue  <= '0;
      end
    end
  end

endmodule

// File: doc/fb_vga_reader.md
FB_VGA_READER -- requirements
Module: fb_vga_reader

Interface
REQ-001 SHALL have parameter c_img_cols, default 320, meaning stored image width in pixels.
REQ-002 SHALL have parameter c_img_rows, default 240, meaning stored image height in pixels.
REQ-003 SHALL have parameter c_nb_img_pxls, default 17, meaning frame-buffer address width.
REQ-004 SHALL have parameter c_nb_buf, default 12, meaning frame-buffer word width, packed RGB444 as red[11:8], green[7:4], blue[3:0].
REQ-005 SHALL have port clk, input, 1, 25 MHz pixel clock; the block has one clock only.
REQ-006 SHALL have port rst_n, input, 1, reset that is asynchronous and active-low.
REQ-007 SHALL have port addrb, output, c_nb_img_pxls, frame-buffer read address.
REQ-008 SHALL have port doutb, input, c_nb_buf, frame-buffer read data, valid one clk after addrb.
REQ-009 SHALL have port vga_hsync, output, 1, horizontal sync, active-low.
REQ-010 SHALL have port vga_vsync, output, 1, vertical sync, active-low.
REQ-011 SHALL have ports vga_red, vga_green, vga_blue, output, 4 each, pixel colour.
REQ-012 SHALL have port frame_end, output, 1, single-cycle pulse marking the end of the visible frame.

Function
REQ-013 SHALL run counter h over 0..799 and counter v over 0..524; h wraps 799->0 and increments v; v wraps 524->0 when h wraps.
REQ-014 SHALL treat a position as visible when h<640 and v<480.
REQ-015 SHALL drive hsync low exactly for h in 656..751 and vsync low exactly for v in 490..491.
REQ-016 SHALL upscale 2x in both axes: visible pixel (h,v) reads address (v>>1)*c_img_cols + (h>>1).
REQ-017 SHALL compute the address without a multiplier: row_base register plus h>>1; row_base adds c_img_cols when h wraps and v is odd and v<479; row_base clears to 0 when v wraps.
REQ-018 SHALL register addrb one clk after the counter state; addrb holds its last value when not visible.
REQ-019 SHALL register all VGA outputs with a fixed 3-clk latency from counter state: counter (t) -> addrb (t+1) -> doutb (t+2) -> outputs (t+3); sync and visible flags SHALL be delayed through a matching pipeline.
REQ-020 SHALL output doutb colour fields when the delayed visible flag is 1, else all colour outputs 0.
REQ-021 SHALL assert frame_end for exactly one clk, the clk after counter state (h=639, v=479), not pipeline-delayed.
REQ-022 SHALL never drive addrb beyond c_img_cols*c_img_rows-1 (76 799).

Reset
REQ-023 SHALL, while rst_n=0, hold h=0, v=0, row_base=0, addrb=0, pipeline flags cleared, vga_hsync=1, vga_vsync=1, colour outputs=0, frame_end=0.
REQ-024 SHALL, on rst_n assertion mid-frame, take reset values immediately without waiting for clk; after release the first visible pixel appears on outputs 3 clk after the first counter step from (0,0).

Verification
REQ-025 SHALL verify: release reset, doutb=0xF0A -> red=0xF, green=0x0, blue=0xA from 3rd clk edge on; addrb sequence 0,0,1,1,2,2... across line 0.
REQ-026 SHALL verify: monitor one frame -> 800 clk per line, 525 lines; hsync low 96 clk starting 3 clk after h=656; vsync low 2 lines.
REQ-027 SHALL verify: lines 0,1 read addresses 0..319; line 2 starts at 320; line 479 ends at 76 799; no address >76 799 ever.
REQ-028 SHALL verify: doutb=0xFFF held constant -> colour outputs 0 whenever delayed h>=640 or v>=480.
REQ-029 SHALL verify: frame_end pulses once per 420 000 clk, one clk wide, after counter (639,479).
REQ-030 SHALL verify: rst_n pulled low asynchronously at (h=300,v=200) -> outputs at reset values before next clk edge; after release, timing restarts from (0,0).
